// File: rtl/serial_byte_tx.sv
// Byte-wide FIFO feeding a parallel-to-serial shifter; emits one payload bit per
// cycle with back-to-back bytes and no gap cycles.
module serial_byte_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   serial_out,
  output logic                   bit_valid,
  output logic                   byte_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          serial_q, serial_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          push;
  logic          pop;

  // Ready looks only at the registered count, so a full FIFO refuses even while popping.
  assign data_ready = (count_q < CW'(DEPTH)) && !reset;
  assign push       = data_valid && data_ready;

  assign serial_out = serial_q;
  assign bit_valid  = valid_q;
  assign byte_done  = done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q == SHIFT) || (count_q != '0);

  // Shifter control; the outgoing bit is taken from the next-state shift register
  // so that serial_out is registered yet appears the cycle after the pop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == BW'(7)) begin
          bit_cnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d  = (state_d == SHIFT);
    serial_d = valid_d && (LSB_FIRST ? shift_d[0] : shift_d[7]);
    done_d   = valid_d && (bit_cnt_d == BW'(7));
  end

  // Circular-buffer pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule
